// File: rtl/alu_muldiv.sv
// alu_muldiv -- iterative RV32M multiply/divide unit for the execute stage.
//
// Radix-2, one bit per cycle: shift-add multiplier and restoring divider.
// Operands are latched as magnitudes and the sign is fixed up in a final FIX
// cycle. Divide-by-zero and signed overflow (DIV/REM of MIN by -1) skip the
// iteration and finish in one cycle.
//
// Ports:
//   CLK      in  1      clock, rising edge
//   RESETn   in  1      asynchronous active-low reset
//   Start    in  1      request pulse, sampled in IDLE or DONE
//   Funct3   in  3      0 MUL 1 MULH 2 MULHSU 3 MULHU 4 DIV 5 DIVU 6 REM 7 REMU
//   Src_A    in  WIDTH  rs1 / dividend
//   Src_B    in  WIDTH  rs2 / divisor
//   Kill     in  1      abort op in flight; suppresses a simultaneous Start
//   Busy     out 1      high in CALC and FIX
//   Done     out 1      one-cycle pulse in DONE
//   Result   out WIDTH  registered result, held until the next Done
//
// Build option: define ALU_MULDIV_DIV_EN to include the divide datapath.
// Without it Funct3 4-7 complete in one cycle with Result = 0.

module alu_muldiv #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             CLK,
   input  logic             RESETn,
   input  logic             Start,
   input  logic [2:0]       Funct3,
   input  logic [WIDTH-1:0] Src_A,
   input  logic [WIDTH-1:0] Src_B,
   input  logic             Kill,
   output logic             Busy,
   output logic             Done,
   output logic [WIDTH-1:0] Result
);

   localparam int unsigned CW = $clog2(WIDTH);
   localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_e;

   state_e               state_q, state_d;
   logic [2*WIDTH-1:0]   prod_q, prod_d;    // {acc/remainder, multiplier/dividend}
   logic [WIDTH-1:0]     opnd_q, opnd_d;    // multiplicand / divisor magnitude
   logic [WIDTH-1:0]     result_q, result_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [2:0]           f3_q, f3_d;
   logic                 neg_res_q, neg_res_d;
`ifdef ALU_MULDIV_DIV_EN
   logic                 neg_rem_q, neg_rem_d;
`endif

   // Operand conditioning at accept
   logic             a_signed, b_signed, sa, sb;
   logic [WIDTH-1:0] mag_a, mag_b;
   logic             spec_hit;
   logic [WIDTH-1:0] spec_val;

   always_comb begin
      a_signed = Funct3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd6};
      b_signed = Funct3 inside {3'd0, 3'd1, 3'd4, 3'd6};
      sa       = a_signed & Src_A[WIDTH-1];
      sb       = b_signed & Src_B[WIDTH-1];
      mag_a    = sa ? -Src_A : Src_A;
      mag_b    = sb ? -Src_B : Src_B;
   end

   always_comb begin
      spec_hit = 1'b0;
      spec_val = '0;
`ifdef ALU_MULDIV_DIV_EN
      if (Funct3[2]) begin
         if (Src_B == '0) begin
            spec_hit = 1'b1;
            spec_val = Funct3[1] ? Src_A : '1;
         end else if (!Funct3[0] && Src_A == MIN_NEG && Src_B == '1) begin
            spec_hit = 1'b1;
            spec_val = Funct3[1] ? '0 : Src_A;
         end
      end
`else
      if (Funct3[2]) begin
         spec_hit = 1'b1;
         spec_val = '0;
      end
`endif
   end

   // One iteration step
   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH-1:0] step_val;
`ifdef ALU_MULDIV_DIV_EN
   logic [WIDTH:0]     div_trial, div_diff;
`endif

   always_comb begin
      // Carry out of the add shifts into the top of the product
      mul_sum  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + {1'b0, (prod_q[0] ? opnd_q : {WIDTH{1'b0}})};
      step_val = {mul_sum, prod_q[WIDTH-1:1]};
`ifdef ALU_MULDIV_DIV_EN
      // Restoring step: shift next dividend bit into the remainder, trial subtract
      div_trial = prod_q[2*WIDTH-1:WIDTH-1];
      div_diff  = div_trial - {1'b0, opnd_q};
      if (f3_q[2]) begin
         if (div_diff[WIDTH])
            step_val = {div_trial[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b0};
         else
            step_val = {div_diff[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b1};
      end
`endif
   end

   // Sign correction and result selection
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   fix_val;
`ifdef ALU_MULDIV_DIV_EN
   logic [WIDTH-1:0]   quo, rem, quo_fix, rem_fix;
`endif

   always_comb begin
      prod_fix = neg_res_q ? -prod_q : prod_q;
      fix_val  = (f3_q[1:0] == 2'd0) ? prod_fix[WIDTH-1:0] : prod_fix[2*WIDTH-1:WIDTH];
`ifdef ALU_MULDIV_DIV_EN
      quo     = prod_q[WIDTH-1:0];
      rem     = prod_q[2*WIDTH-1:WIDTH];
      quo_fix = neg_res_q ? -quo : quo;
      rem_fix = neg_rem_q ? -rem : rem;
      if (f3_q[2])
         fix_val = f3_q[1] ? rem_fix : quo_fix;
`endif
   end

   // Next state
   always_comb begin
      state_d   = state_q;
      prod_d    = prod_q;
      opnd_d    = opnd_q;
      result_d  = result_q;
      cnt_d     = cnt_q;
      f3_d      = f3_q;
      neg_res_d = neg_res_q;
`ifdef ALU_MULDIV_DIV_EN
      neg_rem_d = neg_rem_q;
`endif
      case (state_q)
         S_IDLE, S_DONE: begin
            if (Start && !Kill) begin
               f3_d      = Funct3;
               cnt_d     = CW'(WIDTH - 1);
               neg_res_d = (Funct3 == 3'd2) ? sa : (sa ^ sb);
`ifdef ALU_MULDIV_DIV_EN
               neg_rem_d = sa;
`endif
               prod_d    = {{WIDTH{1'b0}}, (Funct3[2] ? mag_a : mag_b)};
               opnd_d    = Funct3[2] ? mag_b : mag_a;
               if (spec_hit) begin
                  state_d  = S_DONE;
                  result_d = spec_val;
               end else begin
                  state_d  = S_CALC;
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         S_CALC: begin
            if (Kill) begin
               state_d = S_IDLE;
            end else begin
               prod_d = step_val;
               if (cnt_q == '0)
                  state_d = S_FIX;
               else
                  cnt_d = cnt_q - 1'b1;
            end
         end
         S_FIX: begin
            if (Kill) begin
               state_d = S_IDLE;
            end else begin
               result_d = fix_val;
               state_d  = S_DONE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
         state_q   <= S_IDLE;
         prod_q    <= '0;
         opnd_q    <= '0;
         result_q  <= '0;
         cnt_q     <= '0;
         f3_q      <= '0;
         neg_res_q <= 1'b0;
`ifdef ALU_MULDIV_DIV_EN
         neg_rem_q <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         prod_q    <= prod_d;
         opnd_q    <= opnd_d;
         result_q  <= result_d;
         cnt_q     <= cnt_d;
         f3_q      <= f3_d;
         neg_res_q <= neg_res_d;
`ifdef ALU_MULDIV_DIV_EN
         neg_rem_q <= neg_rem_d;
`endif
      end
   end

   assign Busy   = (state_q == S_CALC) || (state_q == S_FIX);
   assign Done   = (state_q == S_DONE);
   assign Result = result_q;

endmodule

// File: tb/tb_alu_muldiv.sv
// tb_alu_muldiv -- directed-vector bench for alu_muldiv (WIDTH = 32).
// Expected values are hand-computed; divide expectations follow the
// ALU_MULDIV_DIV_EN build option.

module tb_alu_muldiv;

   localparam int unsigned W = 32;
`ifdef ALU_MULDIV_DIV_EN
   localparam bit DIV_EN = 1'b1;
`else
   localparam bit DIV_EN = 1'b0;
`endif
   localparam int LAT  = 34;
   localparam int DLAT = DIV_EN ? 34 : 1;

   logic         CLK, RESETn, Start, Kill;
   logic [2:0]   Funct3;
   logic [W-1:0] Src_A, Src_B;
   logic         Busy, Done;
   logic [W-1:0] Result;

   int n_checks = 0;
   int n_errors = 0;

   alu_muldiv #(.WIDTH(W)) dut (
      .CLK(CLK), .RESETn(RESETn), .Start(Start), .Funct3(Funct3),
      .Src_A(Src_A), .Src_B(Src_B), .Kill(Kill),
      .Busy(Busy), .Done(Done), .Result(Result)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   // Presents one op for a single accepting edge; returns in cycle 1
   task automatic issue(input logic [2:0] f3, input logic [W-1:0] a, input logic [W-1:0] b);
      Start  = 1'b1;
      Funct3 = f3;
      Src_A  = a;
      Src_B  = b;
      step();
      Start  = 1'b0;
   endtask

   // Counts cycles until Done (bounded); cycle index n0 at entry
   task automatic wait_done(input int n0, output int n, output int nbusy);
      n     = n0;
      nbusy = 0;
      while (!Done && n < 200) begin
         if (Busy) nbusy++;
         step();
         n++;
      end
   endtask

   task automatic run_op(input string tag, input logic [2:0] f3, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] exp, input int exp_lat);
      int n, nb;
      issue(f3, a, b);
      wait_done(1, n, nb);
      check({tag, " done"}, Done, 1);
      check({tag, " latency"}, n, exp_lat);
      check({tag, " busy_cycles"}, nb, (exp_lat == LAT) ? 33 : 0);
      check({tag, " busy_at_done"}, Busy, 0);
      check({tag, " result"}, Result, exp);
   endtask

   initial begin
      int n, nb, dcnt;
      RESETn = 1'b0;
      Start  = 1'b0;
      Kill   = 1'b0;
      Funct3 = '0;
      Src_A  = '0;
      Src_B  = '0;
      #3;
      check("reset busy", Busy, 0);
      check("reset done", Done, 0);
      check("reset result", Result, 0);
      step();
      RESETn = 1'b1;
      step();

      // Multiply
      run_op("mul_7_m3",  3'd0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, LAT);
      run_op("mulh_min",  3'd1, 32'h80000000, 32'h80000000, 32'h40000000, LAT);
      run_op("mulhu_min", 3'd3, 32'h80000000, 32'h80000000, 32'h40000000, LAT);
      run_op("mulhsu",    3'd2, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, LAT);
      run_op("mulhu_max", 3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, LAT);

      // Divide
      run_op("div_m7_2",  3'd4, 32'hFFFFFFF9, 32'd2, DIV_EN ? 32'hFFFFFFFD : 32'h0, DLAT);
      run_op("rem_m7_2",  3'd6, 32'hFFFFFFF9, 32'd2, DIV_EN ? 32'hFFFFFFFF : 32'h0, DLAT);
      run_op("divu_m7_2", 3'd5, 32'hFFFFFFF9, 32'd2, DIV_EN ? 32'h7FFFFFFC : 32'h0, DLAT);
      run_op("div_100_m7", 3'd4, 32'd100, 32'hFFFFFFF9, DIV_EN ? 32'hFFFFFFF2 : 32'h0, DLAT);
      run_op("remu_100_7", 3'd7, 32'd100, 32'd7,        DIV_EN ? 32'd2 : 32'h0, DLAT);

      // Special cases
      run_op("divu_by0", 3'd5, 32'd5,        32'd0,        DIV_EN ? 32'hFFFFFFFF : 32'h0, 1);
      run_op("rem_by0",  3'd6, 32'd5,        32'd0,        DIV_EN ? 32'd5 : 32'h0, 1);
      run_op("div_ovf",  3'd4, 32'h80000000, 32'hFFFFFFFF, DIV_EN ? 32'h80000000 : 32'h0, 1);
      run_op("rem_ovf",  3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h0, 1);

      // Known nonzero result before kill
      run_op("mul_6_7", 3'd0, 32'd6, 32'd7, 32'd42, LAT);
      step();

      // Kill at cycle 10
      issue(3'd0, 32'd3, 32'd5);
      repeat (9) step();
      Kill = 1'b1;
      step();
      Kill = 1'b0;
      check("kill busy", Busy, 0);
      dcnt = 0;
      for (int i = 0; i < 40; i++) begin
         if (Done) dcnt++;
         step();
      end
      check("kill no_done", dcnt, 0);
      check("kill result_held", Result, 32'd42);
      run_op("after_kill", 3'd0, 32'd3, 32'd5, 32'd15, LAT);
      step();

      // Kill in IDLE suppresses Start
      Kill = 1'b1;
      issue(3'd0, 32'd9, 32'd9);
      Kill = 1'b0;
      check("idle_kill busy", Busy, 0);
      check("idle_kill done", Done, 0);
      step();

      // Start while busy is ignored
      issue(3'd3, 32'h80000000, 32'h80000000);
      repeat (4) step();
      issue(3'd0, 32'd2, 32'd3);
      wait_done(6, n, nb);
      check("busy_start done", Done, 1);
      check("busy_start latency", n, LAT);
      check("busy_start result", Result, 32'h40000000);
      step();
      check("busy_start no_second_op", Busy, 0);

      // Back-to-back
      run_op("b2b_first", 3'd0, 32'd6, 32'd7, 32'd42, LAT);
      issue(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF);
      check("b2b accepted", Busy, 1);
      wait_done(1, n, nb);
      check("b2b done", Done, 1);
      check("b2b latency", n, LAT);
      check("b2b result", Result, 32'hFFFFFFFE);
      step();

      // Asynchronous reset mid-CALC
      issue(3'd0, 32'd11, 32'd13);
      repeat (5) step();
      #2;
      RESETn = 1'b0;
      #1;
      check("async_rst busy", Busy, 0);
      check("async_rst done", Done, 0);
      check("async_rst result", Result, 0);
      step();
      RESETn = 1'b1;
      step();
      run_op("after_rst", 3'd0, 32'd11, 32'd13, 32'd143, LAT);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/alu_muldiv.md
# alu_muldiv

- Iterative RV32M multiply/divide unit, parametrised in operand width.
- Sits beside the single-cycle ALU in the execute stage. The pipeline issues an M-extension op with a one-cycle start pulse, stalls while `Busy` is high, and captures `Result` on the `Done` pulse.
- Radix-2 datapath, one bit per cycle: shift-add multiplier and restoring divider.
- RISC-V divide-by-zero and signed-overflow cases bypass the iteration.

## Interface
- `WIDTH`, 32: operand/result width. Must be ≥ 4.
- `CLK` in 1: clock, rising-edge active.
- `RESETn` in 1: asynchronous, active-low reset.
- `Start` in 1: request pulse. Sampled only in IDLE or DONE.
- `Funct3` in 3: op select. 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- `Src_A` in WIDTH: rs1 operand / dividend. Sampled with `Start`.
- `Src_B` in WIDTH: rs2 operand / divisor. Sampled with `Start`.
- `Kill` in 1: abort the op in flight (pipeline flush).
- `Busy` out 1: high in CALC and FIX.
- `Done` out 1: one-cycle pulse, high in DONE.
- `Result` out WIDTH: registered result. Held until the next `Done`.

## Operation
**States:** IDLE, CALC, FIX, DONE.

**Accept**
- Occurs when `Start`=1 and state is IDLE or DONE.
- Latches the operands as magnitudes; for signed ops, latches the sign flags.
- Latches `Funct3`, clears the accumulator, sets the counter to WIDTH-1, and goes to CALC.

**Special cases, detected at accept**
- Divisor zero: DIV/DIVU → all-ones; REM/REMU → `Src_A`.
- DIV with `Src_A` = most-negative and `Src_B` = -1 → `Src_A`; REM of the same pair → 0.
- For these cases, go directly to DONE; CALC and FIX are skipped.

**CALC**
- One partial product, or one quotient bit, per cycle.
- The counter decrements each cycle; at 0, go to FIX.
- Multiply uses a 2·WIDTH product register.

**FIX**
- Apply sign correction:
  - MUL/MULH: negate if sign(A) ≠ sign(B).
  - MULHSU: negate if sign(A) (B treated as unsigned).
  - DIV: negate the quotient if the signs differ.
  - REM: the remainder takes the sign of the dividend.
- Write `Result`:
  - MUL → low half of the product; MULH/MULHSU/MULHU → high half.
  - DIV/DIVU → quotient; REM/REMU → remainder.
- Go to DONE.

**DONE**
- `Done`=1 for one cycle.
- Next state: CALC (or DONE again for a special case) if `Start`=1, otherwise IDLE.

**Kill**
- In CALC or FIX: go to IDLE; `Result` is unchanged and no `Done` is produced.
- Kill has priority over `Start`.
- In IDLE/DONE, Kill only suppresses a simultaneous `Start`.

**Other boundary rules**
- `Start` while `Busy`: ignored, no queueing.
- Reset mid-operation: all state is cleared immediately and the op is lost.

## Timing
- Reset values: state IDLE, `Busy`=0, `Done`=0, `Result`=0, counter 0.
- Normal op, with the accepting edge as edge 0:
  - `Busy`=1 after edges 0..WIDTH.
  - `Done`=1 for the single cycle after edge WIDTH+1.
  - Latency: WIDTH+2 cycles from `Start` to `Done` (34 for WIDTH=32).
- Special case: `Done` is high in the cycle after edge 0; `Busy` stays 0.
- Back-to-back: `Start` during `Done` is accepted, with no idle bubble.
- `Result` changes only on the edge that enters DONE.

## Configuration
**`ALU_MULDIV_DIV_EN`**
- Defined: the full divide datapath (DIV/DIVU/REM/REMU) is compiled in.
- Undefined:
  - The divider registers and subtractor are removed.
  - Funct3 4–7 are treated as a special case: DONE after one cycle with `Result`=0.
  - Multiply ops are unchanged.

## Test plan
- MUL, A=7, B=0xFFFFFFFD (-3) → `Result`=0xFFFFFFEB, `Done` 34 cycles after `Start`, `Busy` high for cycles 1–33.
- MULH and MULHU, A=B=0x80000000 → MULH 0x40000000, MULHU 0x40000000. MULHSU with A=0xFFFFFFFF, B=2 → 0xFFFFFFFF.
- DIV and REM, A=0xFFFFFFF9 (-7), B=2 → DIV 0xFFFFFFFD, REM 0xFFFFFFFF. DIVU of the same operands → 0x7FFFFFFC.
- Special cases, each with `Done` the cycle after `Start` and `Busy` never high:
  - DIVU 5/0 → 0xFFFFFFFF; REM 5/0 → 5.
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM of the same pair → 0.
- `Kill` at cycle 10 of a MUL → no `Done`, `Result` keeps its prior value, next `Start` accepted normally. `Start` while `Busy` → ignored.
- `RESETn` low mid-CALC → `Busy`/`Done`/`Result` go to 0 asynchronously. Back-to-back `Start` on the `Done` cycle → second `Done` exactly 34 cycles later.
